// File: rtl/formal_chk_pkg.sv
// Shared types and helpers for the formal output checker.
// Contents:
//   chk_state_e - run state of the checker (IDLE, SKIP, CHECK, DONE)
//   all_ones    - value with the low w bits set (w <= 32)
//   sat_inc     - increment that sticks at a ceiling instead of wrapping
package formal_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  function automatic logic [31:0] all_ones(input int unsigned w);
    logic [63:0] t;
    t = (64'd1 << w) - 64'd1;
    return t[31:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/formal_output_compare.sv
// Registered masked-XOR compare stage.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   valid_i      - sample to compare this cycle
//   a_i, b_i     - the two output vectors being compared
//   mask_i       - 1 = bit compared, 0 = don't-care
//   valid_o      - registered copy of valid_i
//   diff_o       - registered (a ^ b) & mask
//   mismatch_o   - registered OR-reduction of diff
module formal_output_compare #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             mismatch_o
);

  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             valid_q;
  logic             mismatch_q;

  assign diff_d = (a_i ^ b_i) & mask_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      diff_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      valid_q    <= valid_i;
      diff_q     <= diff_d;
      mismatch_q <= |diff_d;
    end
  end

  assign valid_o    = valid_q;
  assign diff_o     = diff_q;
  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/formal_output_checker.sv
// Self-checking comparator for a formal-verification pair (fabric vs benchmark).
// After start, SKIP_VECTORS valid samples are ignored, then NUM_VECTORS valid
// samples are compared through a registered masked-XOR stage; results land one
// cycle after the sampling edge.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SKIP  | discarding warm-up samples
//   CHECK | comparing samples, accumulating results
//   DONE  | run finished, results held until next start
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - begin a run (honoured in IDLE/DONE only)
//   sample_valid     - fpga_out/bench_out/care_mask valid this cycle
//   fpga_out         - fabric outputs
//   bench_out        - reference benchmark outputs
//   care_mask        - 1 = bit compared
//   busy, done, pass - run status
//   mismatch_pulse   - one cycle per mismatching checked vector
//   err_count        - saturating count of mismatching vectors
//   first_err_idx    - post-skip index of first mismatch (all-ones if none)
//   first_err_bits   - masked XOR of first mismatching vector
//   err_bits_sticky  - OR of masked XOR over the run
module formal_output_checker
  import formal_chk_pkg::*;
#(
  parameter int unsigned OUT_WIDTH    = 1,
  parameter int unsigned NUM_VECTORS  = 10,
  parameter int unsigned SKIP_VECTORS = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [OUT_WIDTH-1:0] fpga_out,
  input  logic [OUT_WIDTH-1:0] bench_out,
  input  logic [OUT_WIDTH-1:0] care_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] first_err_idx,
  output logic [OUT_WIDTH-1:0] first_err_bits,
  output logic [OUT_WIDTH-1:0] err_bits_sticky
);

  localparam int unsigned SKIP_W = (SKIP_VECTORS > 0) ? $clog2(SKIP_VECTORS + 1) : 1;
  localparam int unsigned REM_W  = $clog2(NUM_VECTORS + 1);
  localparam logic [31:0] CNT_MAX32 = all_ones(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_MAX32[CNT_WIDTH-1:0];
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_VECTORS);
  localparam logic [REM_W-1:0]  REM_LOAD  = REM_W'(NUM_VECTORS);

  chk_state_e           state_q, state_d;
  logic [SKIP_W-1:0]    skip_q, skip_d;
  logic [REM_W-1:0]     remain_q, remain_d;
  logic [CNT_WIDTH-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0] first_idx_q, first_idx_d;
  logic [OUT_WIDTH-1:0] first_bits_q, first_bits_d;
  logic [OUT_WIDTH-1:0] sticky_q, sticky_d;
  logic                 pulse_q, pulse_d;

  logic                 accept;
  logic                 cmp_valid;
  logic [OUT_WIDTH-1:0] cmp_diff;
  logic                 cmp_mismatch;
  logic [31:0]          err_inc;
  logic [31:0]          idx_inc;

  // Remaining-vector down-counter gates acceptance so a sample arriving while
  // the last result is still in the compare register is not taken.
  assign accept = sample_valid && (state_q == CHECK) && (remain_q != '0);

  formal_output_compare #(
    .WIDTH(OUT_WIDTH)
  ) u_compare (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (accept),
    .a_i       (fpga_out),
    .b_i       (bench_out),
    .mask_i    (care_mask),
    .valid_o   (cmp_valid),
    .diff_o    (cmp_diff),
    .mismatch_o(cmp_mismatch)
  );

  assign err_inc = sat_inc(32'(err_count_q), CNT_MAX32);
  assign idx_inc = sat_inc(32'(vec_idx_q), CNT_MAX32);

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    remain_d     = remain_q;
    vec_idx_d    = vec_idx_q;
    err_count_d  = err_count_q;
    first_idx_d  = first_idx_q;
    first_bits_d = first_bits_q;
    sticky_d     = sticky_q;
    pulse_d      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          skip_d       = SKIP_LOAD;
          remain_d     = REM_LOAD;
          vec_idx_d    = '0;
          err_count_d  = '0;
          first_idx_d  = CNT_MAX;
          first_bits_d = '0;
          sticky_d     = '0;
          state_d      = (SKIP_VECTORS > 0) ? SKIP : CHECK;
        end
      end
      SKIP: begin
        if (sample_valid) begin
          if (skip_q <= SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = CHECK;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
      end
      CHECK: begin
        if (accept) begin
          remain_d = remain_q - REM_W'(1);
        end
        if (cmp_valid) begin
          vec_idx_d = idx_inc[CNT_WIDTH-1:0];
          sticky_d  = sticky_q | cmp_diff;
          if (cmp_mismatch) begin
            err_count_d = err_inc[CNT_WIDTH-1:0];
            pulse_d     = 1'b1;
            // err_count saturates rather than wraps, so zero means no mismatch yet
            if (err_count_q == '0) begin
              first_idx_d  = vec_idx_q;
              first_bits_d = cmp_diff;
            end
          end
          if (remain_q == '0) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      skip_q       <= '0;
      remain_q     <= '0;
      vec_idx_q    <= '0;
      err_count_q  <= '0;
      first_idx_q  <= CNT_MAX;
      first_bits_q <= '0;
      sticky_q     <= '0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      remain_q     <= remain_d;
      vec_idx_q    <= vec_idx_d;
      err_count_q  <= err_count_d;
      first_idx_q  <= first_idx_d;
      first_bits_q <= first_bits_d;
      sticky_q     <= sticky_d;
      pulse_q      <= pulse_d;
    end
  end

  assign busy            = (state_q == SKIP) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_count_q == '0);
  assign mismatch_pulse  = pulse_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_bits  = first_bits_q;
  assign err_bits_sticky = sticky_q;

endmodule

// File: tb/tb_formal_output_checker.sv
// Directed bench for formal_output_checker: a 4-bit/skip-1/10-vector instance
// and a 1-bit/no-skip/6-vector instance with a 2-bit error counter.
module tb_formal_output_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start_a, valid_a;
  logic [3:0]  f_a, b_a, m_a;
  logic        busy_a, done_a, pass_a, mp_a;
  logic [15:0] ec_a, fi_a;
  logic [3:0]  fb_a, st_a;

  logic        start_b, valid_b;
  logic [0:0]  f_b, b_b, m_b;
  logic        busy_b, done_b, pass_b, mp_b;
  logic [1:0]  ec_b, fi_b;
  logic [0:0]  fb_b, st_b;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int p0;

  formal_output_checker #(
    .OUT_WIDTH(4), .NUM_VECTORS(10), .SKIP_VECTORS(1), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sample_valid(valid_a),
    .fpga_out(f_a), .bench_out(b_a), .care_mask(m_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_pulse(mp_a),
    .err_count(ec_a), .first_err_idx(fi_a), .first_err_bits(fb_a),
    .err_bits_sticky(st_a)
  );

  formal_output_checker #(
    .OUT_WIDTH(1), .NUM_VECTORS(6), .SKIP_VECTORS(0), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sample_valid(valid_b),
    .fpga_out(f_b), .bench_out(b_b), .care_mask(m_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_pulse(mp_b),
    .err_count(ec_b), .first_err_idx(fi_b), .first_err_bits(fb_b),
    .err_bits_sticky(st_b)
  );

  always @(posedge clk) begin
    if (mp_a === 1'b1) pulses_a <= pulses_a + 1;
    if (mp_b === 1'b1) pulses_b <= pulses_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [3:0] f, input logic [3:0] b, input logic [3:0] m);
    f_a = f; b_a = b; m_a = m; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic f, input logic b, input logic m);
    f_b = f; b_b = b; m_b = m; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_pulse_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_a = 0; valid_a = 0; f_a = 0; b_a = 0; m_a = 0;
    start_b = 0; valid_b = 0; f_b = 0; b_b = 0; m_b = 0;
    gap(2);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_pulse", 32'(mp_a), 0);
    chk("rst_errcnt", 32'(ec_a), 0);
    chk("rst_firstidx", 32'(fi_a), 32'hFFFF);
    chk("rst_firstbits", 32'(fb_a), 0);
    chk("rst_sticky", 32'(st_a), 0);
    chk("rst_b_firstidx", 32'(fi_b), 32'h3);
    rst_n = 1'b1;
    gap(1);

    // all vectors match
    start_pulse_a();
    chk("t1_busy", 32'(busy_a), 1);
    send_a(4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 10; i++) send_a(4'(i), 4'(i), 4'hF);
    chk("t1_done_early", 32'(done_a), 0);
    gap(1);
    chk("t1_done", 32'(done_a), 1);
    chk("t1_pass", 32'(pass_a), 1);
    chk("t1_errcnt", 32'(ec_a), 0);
    chk("t1_firstidx", 32'(fi_a), 32'hFFFF);
    chk("t1_busy_end", 32'(busy_a), 0);

    // mismatches on checked vectors 3, 4, 7; skip vector mismatches but is ignored
    p0 = pulses_a;
    start_pulse_a();
    chk("t2_clear_done", 32'(done_a), 0);
    send_a(4'hF, 4'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      send_a(4'hA, 4'h8, 4'hF);
      else if (i == 4) send_a(4'h5, 4'h4, 4'hF);
      else if (i == 7) send_a(4'h2, 4'h0, 4'hF);
      else             send_a(4'h3, 4'h3, 4'hF);
      if (i == 3) chk("t2_pulse_not_yet", 32'(mp_a), 0);
      if (i == 4) begin
        chk("t2_pulse", 32'(mp_a), 1);
        chk("t2_errcnt_mid", 32'(ec_a), 1);
      end
    end
    gap(1);
    chk("t2_done", 32'(done_a), 1);
    chk("t2_errcnt", 32'(ec_a), 3);
    chk("t2_firstidx", 32'(fi_a), 3);
    chk("t2_firstbits", 32'(fb_a), 32'h2);
    chk("t2_sticky", 32'(st_a), 32'h3);
    chk("t2_pass", 32'(pass_a), 0);
    gap(1);
    chk("t2_pulses", 32'(pulses_a - p0), 3);

    // differences only on masked-off bits, plus all-zero masks
    start_pulse_a();
    chk("t3_clear_errcnt", 32'(ec_a), 0);
    chk("t3_clear_firstidx", 32'(fi_a), 32'hFFFF);
    chk("t3_clear_sticky", 32'(st_a), 0);
    send_a(4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send_a(4'hC, 4'h0, 4'h3);
      else            send_a(4'hF, 4'h0, 4'h0);
    end
    gap(1);
    chk("t3_done", 32'(done_a), 1);
    chk("t3_errcnt", 32'(ec_a), 0);
    chk("t3_sticky", 32'(st_a), 0);
    chk("t3_pass", 32'(pass_a), 1);

    // async reset in CHECK after two errors
    start_pulse_a();
    send_a(4'h0, 4'h0, 4'hF);
    send_a(4'h1, 4'h0, 4'hF);
    send_a(4'h2, 4'h0, 4'hF);
    send_a(4'h0, 4'h0, 4'hF);
    gap(1);
    chk("t5_errcnt_pre", 32'(ec_a), 2);
    chk("t5_busy_pre", 32'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_done", 32'(done_a), 0);
    chk("t5_errcnt", 32'(ec_a), 0);
    chk("t5_firstidx", 32'(fi_a), 32'hFFFF);
    chk("t5_firstbits", 32'(fb_a), 0);
    chk("t5_sticky", 32'(st_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(1);
    start_pulse_a();
    send_a(4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 10; i++) send_a(4'h6, 4'h6, 4'hF);
    gap(1);
    chk("t5_rerun_done", 32'(done_a), 1);
    chk("t5_rerun_pass", 32'(pass_a), 1);
    chk("t5_rerun_errcnt", 32'(ec_a), 0);

    // start cycle sample not consumed; start while busy ignored; 5-cycle gaps
    start_a = 1'b1;
    f_a = 4'h1; b_a = 4'h0; m_a = 4'hF; valid_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; valid_a = 1'b0;
    gap(5);
    start_pulse_a();
    gap(5);
    send_a(4'h0, 4'h0, 4'hF);
    gap(5);
    send_a(4'h4, 4'h0, 4'hF);
    gap(5);
    start_pulse_a();
    chk("t6_errcnt_kept", 32'(ec_a), 1);
    for (int i = 1; i < 10; i++) begin
      send_a(4'h9, 4'h9, 4'hF);
      if (i == 9) begin
        gap(1);
      end else begin
        gap(5);
        if (i == 8) chk("t6_done_early", 32'(done_a), 0);
      end
    end
    chk("t6_done", 32'(done_a), 1);
    chk("t6_errcnt", 32'(ec_a), 1);
    chk("t6_firstidx", 32'(fi_a), 0);
    chk("t6_firstbits", 32'(fb_a), 32'h4);

    // 2-bit counter saturation, no skip
    p0 = pulses_b;
    start_pulse_b();
    chk("t4_busy", 32'(busy_b), 1);
    for (int i = 0; i < 6; i++) begin
      send_b(1'b1, 1'b0, 1'b1);
      if (i == 3) chk("t4_errcnt_sat", 32'(ec_b), 3);
      if (i == 5) chk("t4_errcnt_nowrap", 32'(ec_b), 3);
    end
    gap(1);
    chk("t4_done", 32'(done_b), 1);
    chk("t4_errcnt", 32'(ec_b), 3);
    chk("t4_firstidx", 32'(fi_b), 0);
    chk("t4_pass", 32'(pass_b), 0);
    chk("t4_sticky", 32'(st_b), 1);
    gap(1);
    chk("t4_pulses", 32'(pulses_b - p0), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
